// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forward selects, timing
// constants, mult/div opcodes and tag-pipeline record types.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_RSVD = 2'd3
  } md_op_e;

  localparam logic [1:0] TNEW_LINK   = 2'd0;
  localparam logic [1:0] TNEW_ALU    = 2'd1;
  localparam logic [1:0] TNEW_LOAD   = 2'd2;
  localparam logic [1:0] TUSE_ID     = 2'd0;
  localparam logic [1:0] TUSE_UNUSED = 2'd3;

  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic [4:0] a3;
    logic       we;
    logic [1:0] tnew;
    md_op_e     md_op;
  } ex_tag_t;

  typedef struct packed {
    logic [4:0] a2;
    logic [4:0] a3;
    logic       we;
    logic [1:0] tnew;
  } mem_tag_t;

  typedef struct packed {
    logic [4:0] a3;
    logic       we;
  } wb_tag_t;

  // A stage can supply register a only if it writes a non-zero destination a.
  function automatic logic tag_hit(input logic we, input logic [4:0] a3,
                                   input logic [4:0] a);
    return we && (a3 == a) && (a3 != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Mult/div occupancy counter: loads the operation latency when an op sits
// in EX and counts down to idle.
module md_busy_cnt
  import hazard_ctrl_pkg::*;
(
  input  logic   CLK,
  input  logic   reset,
  input  md_op_e op,
  output logic   busy
);

  logic [3:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else begin
      case (op)
        MD_MULT: r_cnt <= MULT_LAT;
        MD_DIV:  r_cnt <= DIV_LAT;
        default: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      endcase
    end
  end

  assign busy = (r_cnt != 4'd0) || (op != MD_NONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for a 5-stage MIPS pipeline: tracks destination
// tags of in-flight instructions and compares them against the ID operands.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic [4:0] D_A1,
  input  logic [4:0] D_A2,
  input  logic [4:0] D_A3,
  input  logic       D_RegWrite,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [1:0] D_Tnew,
  input  logic [1:0] D_md_op,
  input  logic       D_md_use,
  output logic       STALL,
  output logic       NOP_CLR,
  output logic [1:0] FwdD_rs,
  output logic [1:0] FwdD_rt,
  output logic [1:0] FwdE_rs,
  output logic [1:0] FwdE_rt,
  output logic       FwdM_rt,
  output logic       MD_busy
);

  ex_tag_t  r_ex;
  mem_tag_t r_mem;
  wb_tag_t  r_wb;

  logic     w_data_stall;
  logic     w_md_stall;
  logic     w_stall;
  ex_tag_t  w_ex_next;
  mem_tag_t w_mem_next;

  function automatic logic data_hazard(input logic [4:0] a, input logic [1:0] tuse,
                                       input ex_tag_t ex, input mem_tag_t mem);
    logic ex_hz;
    logic mem_hz;
    ex_hz  = tag_hit(ex.we, ex.a3, a) && (tuse < ex.tnew);
    mem_hz = tag_hit(mem.we, mem.a3, a) && (tuse < mem.tnew);
    return (a != 5'd0) && (tuse != TUSE_UNUSED) && (ex_hz || mem_hz);
  endfunction

  function automatic fwd_sel_e fwd_d(input logic [4:0] a, input ex_tag_t ex,
                                     input mem_tag_t mem, input wb_tag_t wb);
    if (tag_hit(ex.we, ex.a3, a) && (ex.tnew == TNEW_LINK))
      return FWD_EX;
    else if (tag_hit(mem.we, mem.a3, a) && (mem.tnew == TNEW_LINK))
      return FWD_MEM;
    else if (tag_hit(wb.we, wb.a3, a))
      return FWD_WB;
    return FWD_RF;
  endfunction

  function automatic fwd_sel_e fwd_e(input logic [4:0] a, input mem_tag_t mem,
                                     input wb_tag_t wb);
    if (tag_hit(mem.we, mem.a3, a) && (mem.tnew == TNEW_LINK))
      return FWD_MEM;
    else if (tag_hit(wb.we, wb.a3, a))
      return FWD_WB;
    return FWD_RF;
  endfunction

  md_busy_cnt u_md_busy_cnt (
    .CLK   (CLK),
    .reset (reset),
    .op    (r_ex.md_op),
    .busy  (MD_busy)
  );

  assign w_data_stall = data_hazard(D_A1, D_Tuse_rs, r_ex, r_mem) ||
                        data_hazard(D_A2, D_Tuse_rt, r_ex, r_mem);
  // The counter's busy flag already covers an op sitting in EX or counting.
  assign w_md_stall   = D_md_use && MD_busy;
  assign w_stall      = w_data_stall || w_md_stall;

  always_comb begin
    w_ex_next = '0;
    if (!w_stall) begin
      w_ex_next.a1    = D_A1;
      w_ex_next.a2    = D_A2;
      w_ex_next.a3    = D_A3;
      w_ex_next.we    = D_RegWrite && (D_A3 != 5'd0);
      w_ex_next.tnew  = D_Tnew;
      w_ex_next.md_op = md_op_e'(D_md_op);
    end
  end

  assign w_mem_next = '{a2:   r_ex.a2,
                        a3:   r_ex.a3,
                        we:   r_ex.we,
                        tnew: (r_ex.tnew == TNEW_LINK) ? TNEW_LINK : r_ex.tnew - 2'd1};

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= w_ex_next;
      r_mem <= w_mem_next;
      r_wb  <= '{a3: r_mem.a3, we: r_mem.we};
    end
  end

  // NOTE: every output gets a default before the conditional so the block
  // stays purely combinational with no inferred latch.
  always_comb begin
    STALL   = 1'b0;
    NOP_CLR = 1'b0;
    FwdD_rs = FWD_RF;
    FwdD_rt = FWD_RF;
    FwdE_rs = FWD_RF;
    FwdE_rt = FWD_RF;
    FwdM_rt = 1'b0;
    if (!reset) begin
      STALL   = w_stall;
      NOP_CLR = w_stall;
      FwdD_rs = fwd_d(D_A1, r_ex, r_mem, r_wb);
      FwdD_rt = fwd_d(D_A2, r_ex, r_mem, r_wb);
      FwdE_rs = fwd_e(r_ex.a1, r_mem, r_wb);
      FwdE_rt = fwd_e(r_ex.a2, r_mem, r_wb);
      FwdM_rt = tag_hit(r_wb.we, r_wb.a3, r_mem.a2);
    end
  end

endmodule
